// File: rtl/fpu_pkg.sv
// Shared FP constants and types for the add/convert result path.
package fpu_pkg;

  localparam int unsigned FLEN   = 64;
  localparam int unsigned NFLAGS = 5;

  localparam int unsigned DP_BIAS = 1023;
  localparam int unsigned SP_BIAS = 127;

  // Biased double exponents bounding the normal single range
  localparam logic [10:0] SP_EXP_MAX_DP = 11'd1150;
  localparam logic [10:0] SP_EXP_MIN_DP = 11'd897;

  // Low byte of the rebias offset (896); the narrowed exponent only keeps 8 bits
  localparam logic [7:0] DP_SP_REBIAS_LO = 8'(DP_BIAS - SP_BIAS);

  localparam logic [31:0] SP_CANON_NAN = 32'h7FC0_0000;
  localparam logic [31:0] NAN_BOX      = 32'hFFFF_FFFF;

  localparam int unsigned NV = 4;
  localparam int unsigned DZ = 3;
  localparam int unsigned OF = 2;
  localparam int unsigned UF = 1;
  localparam int unsigned NX = 0;

  typedef struct packed {
    logic [FLEN-1:0]   result;
    logic [NFLAGS-1:0] flags;
  } pack_t;

endpackage

// File: rtl/fp_dp_to_sp_pack.sv
// Combinational narrowing of a double-format result to NaN-boxed single,
// with overflow/underflow/inexact flag generation.
module fp_dp_to_sp_pack
  import fpu_pkg::*;
(
  input  logic [FLEN-1:0]   in_result,
  input  logic              precision,
  input  logic [NFLAGS-1:0] in_flags,
  output pack_t             packed_res
);

  logic        sign;
  logic [10:0] exp;
  logic [22:0] man;
  logic [28:0] tail;
  logic [31:0] sp;
  logic [7:0]  sp_exp;
  logic [NFLAGS-1:0] gen_flags;

  assign sign   = in_result[63];
  assign exp    = in_result[62:52];
  assign man    = in_result[51:29];
  assign tail   = in_result[28:0];
  assign sp_exp = exp[7:0] - DP_SP_REBIAS_LO;

  always_comb begin
    sp        = '0;
    gen_flags = '0;
    if (exp == 11'h7FF) begin
      sp = (man != '0) ? SP_CANON_NAN : {sign, 8'hFF, 23'h0};
    end else if (exp == '0) begin
      sp = {sign, 31'h0};
    end else if (exp > SP_EXP_MAX_DP) begin
      sp            = {sign, 8'hFF, 23'h0};
      gen_flags[OF] = 1'b1;
      gen_flags[NX] = 1'b1;
    end else if (exp < SP_EXP_MIN_DP) begin
      sp            = {sign, 31'h0};
      gen_flags[UF] = 1'b1;
      gen_flags[NX] = 1'b1;
    end else begin
      // Upstream already rounded to single; the dropped tail only signals inexact
      sp            = {sign, sp_exp, man};
      gen_flags[NX] = (tail != '0);
    end
  end

  always_comb begin
    packed_res = '0;
    if (precision) begin
      packed_res.result = {NAN_BOX, sp};
      packed_res.flags  = in_flags | gen_flags;
    end else begin
      packed_res.result = in_result;
      packed_res.flags  = in_flags;
    end
  end

endmodule

// File: rtl/fpadd_result_pack.sv
// FP add result output stage: single-precision packing, 2-entry skid buffer
// and sticky fflags accumulator.
module fpadd_result_pack
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FLEN-1:0]   in_result,
  input  logic              in_P,
  input  logic [NFLAGS-1:0] in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FLEN-1:0]   out_result,
  output logic [NFLAGS-1:0] out_flags,
  input  logic              fflags_clr,
  output logic [NFLAGS-1:0] fflags_acc
);

  pack_t packed_in;
  pack_t main_q, main_d, skid_q, skid_d;
  logic  main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic  [NFLAGS-1:0] acc_q, acc_d;
  logic  accept, drain;

  fp_dp_to_sp_pack u_pack (
    .in_result  (in_result),
    .precision  (in_P),
    .in_flags   (in_flags),
    .packed_res (packed_in)
  );

  assign accept = in_valid & ~skid_valid_q;
  assign drain  = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    acc_d        = acc_q;

    // accept implies skid empty, so a full skid never collides with new input
    if (drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = packed_in;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_d       = packed_in;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = packed_in;
        skid_valid_d = 1'b1;
      end
    end

    if (drain) begin
      acc_d = fflags_clr ? main_q.flags : (acc_q | main_q.flags);
    end else if (fflags_clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      acc_q        <= '0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      acc_q        <= acc_d;
    end
  end

  assign in_ready   = ~skid_valid_q;
  assign out_valid  = main_valid_q;
  assign out_result = main_q.result;
  assign out_flags  = main_q.flags;
  assign fflags_acc = acc_q;

endmodule
